fifo_pop_ctrl: RTL and testbench

FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/skid_buffer2.sv | 55 +++++
 rtl/fifo_pop_ctrl.sv | 93 +++++++++
 tb/tb_fifo_pop_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO and its pop controller: state encodings,
// default word width and the skid-buffer credit check.
package fifo_pkg;

    localparam int DATA_W_DEF = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // A new pop fits if the words left in the buffer after this edge, plus the
    // pending read, plus the new one do not exceed the buffer depth.
    function automatic logic credit_ok(
        input logic [1:0] occ,
        input logic       xfer,
        input logic       inflight,
        input int         depth
    );
        int need;
        need = int'(occ) - int'(xfer) + int'(inflight) + 1;
        return (need <= depth);
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry register FIFO holding popped words until the consumer takes them.
// Contents are not reset; only pointers and count are.
module skid_buffer2
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Guard against overflow and underflow; a full buffer accepts a push only alongside a pop.
    always_comb begin
        do_pop_s  = pop & (count_r != 2'd0);
        do_push_s = push & ((count_r != 2'd2) | do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Pops an upstream FIFO with one-cycle read latency into a 2-entry skid buffer,
// using credits so the buffer never overflows even with the consumer stalled.
module fifo_pop_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_read_enable,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_dest,
    output logic [7:0]        pop_count,
    output logic [1:0]        state
);

    logic [1:0]        state_r;
    logic [1:0]        next_state_s;
    logic              inflight_r;
    logic [7:0]        pop_count_r;
    logic [1:0]        occ_s;
    logic [DATA_W-1:0] head_s;
    logic              valid_s;
    logic              xfer_s;
    logic              rd_en_s;

    skid_buffer2 #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_r),
        .push_data (fifo_data_out),
        .pop       (xfer_s),
        .head      (head_s),
        .count     (occ_s)
    );

    // Handshake and pop request; the credit counts the word leaving this edge
    // so a steady stream sustains one pop per cycle.
    always_comb begin
        valid_s = reset & (occ_s != 2'd0);
        xfer_s  = valid_s & out_ready;
        rd_en_s = reset & (state_r == ST_ACTIVE) & enable & ~fifo_empty &
                  credit_ok(occ_s, xfer_s, inflight_r, BUF_DEPTH);
    end

    // Next-state decode; the unused encoding recovers to IDLE.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE:   next_state_s = enable ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: next_state_s = enable ? ST_ACTIVE : ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    next_state_s = ST_ACTIVE;
                end else if ((occ_s == 2'd0) && !inflight_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State, in-flight read flag and transfer counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            inflight_r  <= 1'b0;
            pop_count_r <= 8'd0;
        end else begin
            state_r    <= next_state_s;
            inflight_r <= rd_en_s;
            if (xfer_s) begin
                pop_count_r <= pop_count_r + 8'd1;
            end
        end
    end

    assign fifo_read_enable = rd_en_s;
    assign out_valid        = valid_s;
    assign out_data         = head_s;
    assign out_dest         = head_s[DATA_W-1:DATA_W-2];
    assign pop_count        = pop_count_r;
    assign state            = state_r;

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl with a behavioural one-cycle-latency FIFO model.
module tb_fifo_pop_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [9:0] fifo_data_out = 10'd0;
    logic       fifo_read_enable;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic [1:0] out_dest;
    logic [7:0] pop_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [9:0] mem [0:1023];
    int wp = 0;
    int rp = 0;
    int cyc = 0;
    int n_pops = 0;
    int n_rx = 0;
    int underflow = 0;
    int pop_log [0:1023];
    int rx_cyc [0:1023];
    logic [9:0] rx_data [0:1023];
    logic [1:0] rx_dest [0:1023];

    fifo_pop_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .fifo_empty       (fifo_empty),
        .fifo_data_out    (fifo_data_out),
        .fifo_read_enable (fifo_read_enable),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_dest         (out_dest),
        .pop_count        (pop_count),
        .state            (state)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    // Upstream FIFO model plus pop and transfer logging.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read_enable) begin
            fifo_data_out   <= mem[rp % 1024];
            rp              <= rp + 1;
            pop_log[n_pops] <= cyc;
            n_pops          <= n_pops + 1;
            if (fifo_empty) underflow <= underflow + 1;
        end
        if (out_valid && out_ready) begin
            rx_data[n_rx] <= out_data;
            rx_dest[n_rx] <= out_dest;
            rx_cyc[n_rx]  <= cyc;
            n_rx          <= n_rx + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [9:0] w);
        mem[wp % 1024] = w;
        wp = wp + 1;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
        step(2);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", out_valid); end
        checks++; if (pop_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", pop_count); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rden got %0b expected 0", fifo_read_enable); end
        reset = 1'b1; enable = 1'b0;
        step(1);
    endtask

    task automatic test_basic;
        int bp, br;
        logic [9:0] exp_w [3];
        logic [1:0] exp_d [3];
        exp_w = '{10'h101, 10'h202, 10'h303};
        exp_d = '{2'd1, 2'd2, 2'd3};
        bp = n_pops; br = n_rx;
        for (int i = 0; i < 3; i++) push_word(exp_w[i]);
        enable = 1'b1; out_ready = 1'b1;
        step(10);
        checks++; if (n_pops - bp !== 3) begin errors++; $display("FAIL basic_pops got %0d expected 3", n_pops - bp); end
        checks++; if (pop_log[bp+1] !== pop_log[bp] + 1) begin errors++; $display("FAIL basic_pop1_cycle got %0d expected %0d", pop_log[bp+1], pop_log[bp] + 1); end
        checks++; if (pop_log[bp+2] !== pop_log[bp] + 2) begin errors++; $display("FAIL basic_pop2_cycle got %0d expected %0d", pop_log[bp+2], pop_log[bp] + 2); end
        checks++; if (n_rx - br !== 3) begin errors++; $display("FAIL basic_xfers got %0d expected 3", n_rx - br); end
        checks++; if (rx_cyc[br] !== pop_log[bp] + 2) begin errors++; $display("FAIL basic_latency got %0d expected %0d", rx_cyc[br], pop_log[bp] + 2); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx_data[br+i] !== exp_w[i]) begin errors++; $display("FAIL basic_data[%0d] got %0h expected %0h", i, rx_data[br+i], exp_w[i]); end
            checks++; if (rx_dest[br+i] !== exp_d[i]) begin errors++; $display("FAIL basic_dest[%0d] got %0d expected %0d", i, rx_dest[br+i], exp_d[i]); end
        end
        checks++; if (pop_count !== 8'd3) begin errors++; $display("FAIL basic_count got %0d expected 3", pop_count); end
        checks++; if (underflow !== 0) begin errors++; $display("FAIL basic_underflow got %0d expected 0", underflow); end
        enable = 1'b0;
        step(3);
    endtask

    task automatic test_backpressure;
        int bp, br;
        logic [9:0] exp_w [6];
        exp_w = '{10'h0A1, 10'h152, 10'h2E3, 10'h3F4, 10'h065, 10'h1B6};
        bp = n_pops; br = n_rx;
        for (int i = 0; i < 6; i++) push_word(exp_w[i]);
        out_ready = 1'b0; enable = 1'b1;
        step(8);
        checks++; if (n_pops - bp !== 2) begin errors++; $display("FAIL bp_pops got %0d expected 2", n_pops - bp); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL bp_rden got %0b expected 0", fifo_read_enable); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b expected 1", out_valid); end
        checks++; if (out_data !== 10'h0A1) begin errors++; $display("FAIL bp_head got %0h expected 0a1", out_data); end
        out_ready = 1'b1;
        step(15);
        checks++; if (n_rx - br !== 6) begin errors++; $display("FAIL bp_xfers got %0d expected 6", n_rx - br); end
        checks++; if (n_pops - bp !== 6) begin errors++; $display("FAIL bp_total_pops got %0d expected 6", n_pops - bp); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (rx_data[br+i] !== exp_w[i]) begin errors++; $display("FAIL bp_data[%0d] got %0h expected %0h", i, rx_data[br+i], exp_w[i]); end
        end
        enable = 1'b0;
        step(3);
    endtask

    task automatic test_single;
        int bp, br;
        bp = n_pops; br = n_rx;
        push_word(10'h2C7);
        enable = 1'b1; out_ready = 1'b1;
        step(6);
        checks++; if (n_pops - bp !== 1) begin errors++; $display("FAIL single_pops got %0d expected 1", n_pops - bp); end
        checks++; if (underflow !== 0) begin errors++; $display("FAIL single_underflow got %0d expected 0", underflow); end
        checks++; if (n_rx - br !== 1) begin errors++; $display("FAIL single_xfers got %0d expected 1", n_rx - br); end
        checks++; if (rx_data[br] !== 10'h2C7) begin errors++; $display("FAIL single_data got %0h expected 2c7", rx_data[br]); end
        enable = 1'b0;
        step(3);
    endtask

    task automatic test_drain;
        int bp, br;
        bp = n_pops; br = n_rx;
        push_word(10'h111); push_word(10'h222); push_word(10'h333); push_word(10'h0FF);
        out_ready = 1'b0; enable = 1'b1;
        step(5);
        checks++; if (n_pops - bp !== 2) begin errors++; $display("FAIL drain_fill got %0d expected 2", n_pops - bp); end
        enable = 1'b0;
        step(1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL drain_state got %0d expected 2", state); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL drain_rden got %0b expected 0", fifo_read_enable); end
        step(3);
        checks++; if (n_pops - bp !== 2) begin errors++; $display("FAIL drain_nopop got %0d expected 2", n_pops - bp); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL drain_hold got %0d expected 2", state); end
        out_ready = 1'b1;
        step(5);
        checks++; if (n_rx - br !== 2) begin errors++; $display("FAIL drain_xfers got %0d expected 2", n_rx - br); end
        checks++; if (rx_data[br] !== 10'h111) begin errors++; $display("FAIL drain_data0 got %0h expected 111", rx_data[br]); end
        checks++; if (rx_data[br+1] !== 10'h222) begin errors++; $display("FAIL drain_data1 got %0h expected 222", rx_data[br+1]); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL drain_idle got %0d expected 0", state); end
        wp = rp;
        step(1);
    endtask

    task automatic test_reset_mid;
        int br;
        push_word(10'h3C3); push_word(10'h0C3); push_word(10'h1E1); push_word(10'h2D2);
        out_ready = 1'b0; enable = 1'b1;
        step(5);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_prefill got %0b expected 1", out_valid); end
        reset = 1'b0;
        step(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b expected 0", out_valid); end
        checks++; if (pop_count !== 8'd0) begin errors++; $display("FAIL rmid_count got %0d expected 0", pop_count); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rmid_state got %0d expected 0", state); end
        checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL rmid_rden got %0b expected 0", fifo_read_enable); end
        reset = 1'b1; enable = 1'b0; wp = rp; out_ready = 1'b1;
        br = n_rx;
        step(5);
        checks++; if (n_rx - br !== 0) begin errors++; $display("FAIL rmid_stale got %0d expected 0", n_rx - br); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_valid got %0b expected 0", out_valid); end
    endtask

    task automatic test_wrap;
        int br;
        logic [9:0] w;
        br = n_rx;
        for (int i = 0; i < 257; i++) begin
            w = 10'(i);
            push_word(w);
        end
        enable = 1'b1; out_ready = 1'b1;
        step(275);
        checks++; if (pop_count !== 8'd1) begin errors++; $display("FAIL wrap_count got %0d expected 1", pop_count); end
        checks++; if (n_rx - br !== 257) begin errors++; $display("FAIL wrap_xfers got %0d expected 257", n_rx - br); end
        checks++; if (rx_data[br+100] !== 10'd100) begin errors++; $display("FAIL wrap_data100 got %0h expected 064", rx_data[br+100]); end
        checks++; if (rx_data[br+256] !== 10'd256) begin errors++; $display("FAIL wrap_data256 got %0h expected 100", rx_data[br+256]); end
        checks++; if (underflow !== 0) begin errors++; $display("FAIL wrap_underflow got %0d expected 0", underflow); end
        enable = 1'b0;
        step(3);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_single();
        test_drain();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
